ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 30 +++
 rtl/ram_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for ram_arbiter: FSM states, client ids,
// backend address-map prefixes and the word returned on a backend timeout.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    CL_SDRAM = 2'd0,
    CL_VCPU  = 2'd1,
    CL_VVGA  = 2'd2
  } client_t;

  localparam logic        SDRAM_PREFIX = 1'b0;
  localparam logic [7:0]  VRAM_PREFIX  = 8'h80;
  localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

  function automatic logic [22:0] map_sdram(input logic [21:0] addr);
    return {SDRAM_PREFIX, addr};
  endfunction

  function automatic logic [22:0] map_vram(input logic [14:0] addr);
    return {VRAM_PREFIX, addr};
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Three-client arbiter (sdram, vram_cpu, vram_vga) onto one backend port with a
// single outstanding command. Optional backend timeout: define RAM_ARB_TIMEOUT_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sdram_req,
  input  logic        sdram_write,
  input  logic [21:0] sdram_addr,
  input  logic [31:0] sdram_data_in,
  output logic [31:0] sdram_data_out,
  output logic        sdram_done,
  input  logic        vram_cpu_req,
  input  logic        vram_cpu_write,
  input  logic [14:0] vram_cpu_addr,
  input  logic [31:0] vram_cpu_data_in,
  output logic [31:0] vram_cpu_data_out,
  output logic        vram_cpu_done,
  input  logic        vram_vga_req,
  input  logic [14:0] vram_vga_addr,
  output logic [31:0] vram_vga_data_out,
  output logic        vram_vga_done,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic [22:0] mem_cmd_addr,
  output logic [31:0] mem_cmd_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        timeout_err
);

  arb_state_t  r_state;
  client_t     r_client;
  logic        r_rr_cpu;
  logic        r_cmd_valid;
  logic        r_cmd_write;
  logic [22:0] r_cmd_addr;
  logic [31:0] r_cmd_wdata;
  logic        r_sdram_done;
  logic        r_cpu_done;
  logic        r_vga_done;
  logic [31:0] r_sdram_data;
  logic [31:0] r_cpu_data;
  logic [31:0] r_vga_data;

  logic        w_pick_sdram;
  logic        w_pick_cpu;
  logic        w_tmo_hit;
  logic        w_finish;
  logic        w_latch;
  logic [31:0] w_rsp_word;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;

  assign w_tmo_hit   = (r_state == ST_WAIT) && !mem_rsp_valid &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 32'd1));
  assign timeout_err = r_timeout_err;

  // WAIT-cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) r_tmo_cnt <= '0;
      else                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (w_tmo_hit) r_timeout_err <= 1'b1;
      else           r_timeout_err <= r_timeout_err;
    end
  end
`else
  logic w_tmo_unused;
  assign w_tmo_unused = (TIMEOUT_CYCLES != 32'd0);
  assign w_tmo_hit    = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // vga always wins; r_rr_cpu selects between sdram and vram_cpu on contention
  always_comb begin
    w_pick_sdram = 1'b0;
    w_pick_cpu   = 1'b0;
    if (vram_vga_req) begin
      w_pick_sdram = 1'b0;
      w_pick_cpu   = 1'b0;
    end else if (sdram_req && (!vram_cpu_req || !r_rr_cpu)) begin
      w_pick_sdram = 1'b1;
    end else if (vram_cpu_req) begin
      w_pick_cpu = 1'b1;
    end else begin
      w_pick_sdram = 1'b0;
      w_pick_cpu   = 1'b0;
    end
  end

  // completion source: real response, or timeout fill (always latched)
  always_comb begin
    w_finish = (r_state == ST_WAIT) && (mem_rsp_valid || w_tmo_hit);
    if (mem_rsp_valid) begin
      w_rsp_word = mem_rsp_data;
      w_latch    = !r_cmd_write;
    end else begin
      w_rsp_word = TIMEOUT_FILL;
      w_latch    = 1'b1;
    end
  end

  // arbitration FSM with registered command, done pulses and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_client     <= CL_SDRAM;
      r_rr_cpu     <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= 23'd0;
      r_cmd_wdata  <= 32'd0;
      r_sdram_done <= 1'b0;
      r_cpu_done   <= 1'b0;
      r_vga_done   <= 1'b0;
      r_sdram_data <= 32'd0;
      r_cpu_data   <= 32'd0;
      r_vga_data   <= 32'd0;
    end else begin
      r_sdram_done <= 1'b0;
      r_cpu_done   <= 1'b0;
      r_vga_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (vram_vga_req) begin
            r_client    <= CL_VVGA;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= map_vram(vram_vga_addr);
            r_cmd_wdata <= 32'd0;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_pick_sdram) begin
            r_client    <= CL_SDRAM;
            r_cmd_write <= sdram_write;
            r_cmd_addr  <= map_sdram(sdram_addr);
            r_cmd_wdata <= sdram_data_in;
            r_cmd_valid <= 1'b1;
            r_rr_cpu    <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_pick_cpu) begin
            r_client    <= CL_VCPU;
            r_cmd_write <= vram_cpu_write;
            r_cmd_addr  <= map_vram(vram_cpu_addr);
            r_cmd_wdata <= vram_cpu_data_in;
            r_cmd_valid <= 1'b1;
            r_rr_cpu    <= 1'b0;
            r_state     <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mem_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (w_finish) begin
            r_state <= ST_DONE;
            case (r_client)
              CL_SDRAM: begin
                r_sdram_done <= 1'b1;
                if (w_latch) r_sdram_data <= w_rsp_word;
              end
              CL_VCPU: begin
                r_cpu_done <= 1'b1;
                if (w_latch) r_cpu_data <= w_rsp_word;
              end
              CL_VVGA: begin
                r_vga_done <= 1'b1;
                if (w_latch) r_vga_data <= w_rsp_word;
              end
              default: r_state <= ST_IDLE;
            endcase
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sdram_done        = r_sdram_done;
  assign vram_cpu_done     = r_cpu_done;
  assign vram_vga_done     = r_vga_done;
  assign sdram_data_out    = r_sdram_data;
  assign vram_cpu_data_out = r_cpu_data;
  assign vram_vga_data_out = r_vga_data;
  assign mem_cmd_valid     = r_cmd_valid;
  assign mem_cmd_write     = r_cmd_write;
  assign mem_cmd_addr      = r_cmd_addr;
  assign mem_cmd_wdata     = r_cmd_wdata;

endmodule
